mac_dot_product: RTL and testbench



---
 rtl/mac_dot_product_pkg.sv | 23 ++
 rtl/mac_dot_product_if.sv | 24 ++
 rtl/mac_dot_product_multip_adder.sv | 25 ++
 rtl/mac_dot_product.sv | 108 ++++++++++
 tb/tb_mac_dot_product.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mac_dot_product_pkg.sv
// Shared types and elaboration-time helpers for the dot-product engine:
// state encoding, accumulator width rule and counter sizing.
package mac_dot_product_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Accumulator/result width: BITWIDTH, or doubled when the scale flag is set.
  function automatic int acc_width(input int bitwidth, input int is_double);
    return bitwidth * (is_double + 1);
  endfunction

  // Ceiling log2 with a floor of 1 bit, so VEC_LEN=1 still gets a counter.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mac_dot_product_if.sv
// Operand-in / result-out handshake bundle of the dot-product engine.
interface mac_dot_product_if #(
  parameter int BITWIDTH = 8,
  parameter int ACC_W    = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [BITWIDTH-1:0] in_a;
  logic signed [BITWIDTH-1:0] in_b;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [ACC_W-1:0]    out_data;
  logic                       busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/mac_dot_product_multip_adder.sv
// Combinational signed multiply-add, a*b + c, wrapping modulo 2^ACC_W.
module multip_adder
  import mac_dot_product_pkg::*;
#(
  parameter int BITWIDTH                 = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 0
) (
  input  logic signed [BITWIDTH-1:0]                                        in_a,
  input  logic signed [BITWIDTH-1:0]                                        in_b,
  input  logic signed [acc_width(BITWIDTH, IS_BITWIDTH_DOUBLE_SCALE)-1:0]   in_c,
  output logic signed [acc_width(BITWIDTH, IS_BITWIDTH_DOUBLE_SCALE)-1:0]   out_sum
);
  localparam int ACC_W = acc_width(BITWIDTH, IS_BITWIDTH_DOUBLE_SCALE);

  logic signed [ACC_W-1:0] w_a_ext;
  logic signed [ACC_W-1:0] w_b_ext;
  logic signed [ACC_W-1:0] w_prod;

  // Sign-extend first so the product is formed directly at ACC_W and wraps there.
  assign w_a_ext = ACC_W'(in_a);
  assign w_b_ext = ACC_W'(in_b);
  assign w_prod  = w_a_ext * w_b_ext;
  assign out_sum = w_prod + in_c;

endmodule

// File: rtl/mac_dot_product.sv
// Sequential dot-product engine: accumulates VEC_LEN operand pairs through
// one multip_adder, then holds the scalar result until it is consumed.
module mac_dot_product
  import mac_dot_product_pkg::*;
#(
  parameter int BITWIDTH                 = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 0,
  parameter int VEC_LEN                  = 4
) (
  input  logic              clk,
  input  logic              rst,
  mac_dot_product_if.slave  bus
);
  localparam int ACC_W = acc_width(BITWIDTH, IS_BITWIDTH_DOUBLE_SCALE);
  localparam int CNT_W = clog2_min1(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_count_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] r_out_data;
  logic signed [ACC_W-1:0] w_out_data_nxt;
  logic                    r_out_valid;
  logic                    w_out_valid_nxt;
  logic signed [ACC_W-1:0] w_mac;
  logic                    w_in_ready;
  logic                    w_in_hs;
  logic                    w_out_hs;

  multip_adder #(
    .BITWIDTH                (BITWIDTH),
    .IS_BITWIDTH_DOUBLE_SCALE(IS_BITWIDTH_DOUBLE_SCALE)
  ) u_multip_adder (
    .in_a   (bus.in_a),
    .in_b   (bus.in_b),
    .in_c   (r_acc),
    .out_sum(w_mac)
  );

  // Ready depends on state alone, so there is no in_valid -> in_ready path.
  assign w_in_ready = (r_state == ST_ACCUM);
  assign w_in_hs    = bus.in_valid & w_in_ready;
  assign w_out_hs   = r_out_valid & bus.out_ready;

  // Next-state, accumulator, counter and result-register update.
  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_acc_nxt       = r_acc;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      ST_ACCUM: begin
        if (w_in_hs) begin
          if (r_count == LAST_IDX) begin
            w_out_data_nxt  = w_mac;
            w_out_valid_nxt = 1'b1;
            w_acc_nxt       = '0;
            w_count_nxt     = '0;
            w_state_nxt     = ST_HOLD;
          end else begin
            w_acc_nxt   = w_mac;
            w_count_nxt = r_count + CNT_W'(1);
          end
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (w_out_hs) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = ST_ACCUM;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers; rst drops any partial sum or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_count     <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_acc       <= w_acc_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = (r_count != '0) | r_out_valid;

endmodule

// File: tb/tb_mac_dot_product.sv
// Directed bench: two engines (single and double scale) fed identical stimulus.
module tb_mac_dot_product;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mac_dot_product_if #(.BITWIDTH(8), .ACC_W(8))  u_if0 ();
  mac_dot_product_if #(.BITWIDTH(8), .ACC_W(16)) u_if1 ();

  mac_dot_product #(
    .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(0), .VEC_LEN(4)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(u_if0.slave)
  );

  mac_dot_product #(
    .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(1), .VEC_LEN(4)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(u_if1.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int b);
    u_if0.in_valid = v;  u_if1.in_valid = v;
    u_if0.in_a = 8'(a);  u_if1.in_a = 8'(a);
    u_if0.in_b = 8'(b);  u_if1.in_b = 8'(b);
  endtask

  task automatic set_ready(input logic r);
    u_if0.out_ready = r;
    u_if1.out_ready = r;
  endtask

  // Present one pair and return just after the edge that accepts it.
  task automatic send(input int a, input int b);
    int k;
    drive(1'b1, a, b);
    k = 0;
    while (!u_if0.in_ready && k < 20) begin
      step();
      k++;
    end
    if (k >= 20) check_eq("send_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic idle(input int n, input string tag);
    drive(1'b0, 0, 0);
    repeat (n) begin
      step();
      check_eq(tag, {31'd0, u_if0.out_valid}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0);
    set_ready(1'b1);
    repeat (2) step();
    rst = 1'b0;
    step();
    check_eq("rst_valid", {31'd0, u_if0.out_valid}, 32'd0);
    check_eq("rst_data",  {24'd0, u_if0.out_data},  32'd0);
    check_eq("rst_ready", {31'd0, u_if0.in_ready},  32'd1);
    check_eq("rst_busy",  {31'd0, u_if0.busy},      32'd0);

    // Basic: 1*5+2*6+3*7+4*8 = 70
    send(1, 5); send(2, 6); send(3, 7);
    check_eq("basic_pre_valid", {31'd0, u_if0.out_valid}, 32'd0);
    check_eq("basic_busy_mid",  {31'd0, u_if0.busy},      32'd1);
    send(4, 8);
    drive(1'b0, 0, 0);
    check_eq("basic_valid", {31'd0, u_if0.out_valid}, 32'd1);
    check_eq("basic_data",  {24'd0, u_if0.out_data},  32'd70);
    check_eq("basic_data2", {16'd0, u_if1.out_data},  32'd70);
    check_eq("basic_ready_low", {31'd0, u_if0.in_ready}, 32'd0);
    step();
    check_eq("basic_valid_drop", {31'd0, u_if0.out_valid}, 32'd0);
    check_eq("basic_ready_back", {31'd0, u_if0.in_ready},  32'd1);
    check_eq("basic_busy_done",  {31'd0, u_if0.busy},      32'd0);

    // Signed: -3 - 8 + 0 - 1 = -12
    send(-3, 1); send(2, -4); send(0, 9); send(1, -1);
    drive(1'b0, 0, 0);
    check_eq("signed_data",  {24'd0, u_if0.out_data}, 32'h0000_00F4);
    check_eq("signed_data2", {16'd0, u_if1.out_data}, 32'h0000_FFF4);
    step();

    // Wrap: 300 mod 256 = 44 at 8 bits, 300 at 16 bits
    send(100, 2); send(100, 1); send(0, 0); send(0, 0);
    drive(1'b0, 0, 0);
    check_eq("wrap_data8",  {24'd0, u_if0.out_data}, 32'd44);
    check_eq("wrap_data16", {16'd0, u_if1.out_data}, 32'h0000_012C);
    step();

    // Backpressure: result held, new operands refused
    set_ready(1'b0);
    send(1, 5); send(2, 6); send(3, 7); send(4, 8);
    drive(1'b1, 9, 9);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_valid", {31'd0, u_if0.out_valid}, 32'd1);
      check_eq("bp_data",  {24'd0, u_if0.out_data},  32'd70);
      check_eq("bp_ready", {31'd0, u_if0.in_ready},  32'd0);
    end
    set_ready(1'b1);
    drive(1'b0, 0, 0);
    step();
    check_eq("bp_release_valid", {31'd0, u_if0.out_valid}, 32'd0);
    check_eq("bp_nothing_taken", {31'd0, u_if0.busy},      32'd0);
    send(1, 1); send(1, 1); send(1, 1); send(1, 1);
    drive(1'b0, 0, 0);
    check_eq("bp_next_data", {24'd0, u_if0.out_data}, 32'd4);
    step();

    // Bubbles between accepted pairs
    send(1, 5); idle(1, "bub_valid1");
    send(2, 6); idle(2, "bub_valid2");
    send(3, 7); idle(3, "bub_valid3");
    send(4, 8);
    drive(1'b0, 0, 0);
    check_eq("bub_valid", {31'd0, u_if0.out_valid}, 32'd1);
    check_eq("bub_data",  {24'd0, u_if0.out_data},  32'd70);
    step();

    // Reset mid-vector discards the partial sum
    send(1, 5); send(2, 6);
    drive(1'b0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mrst_valid", {31'd0, u_if0.out_valid}, 32'd0);
    check_eq("mrst_busy",  {31'd0, u_if0.busy},      32'd0);
    check_eq("mrst_ready", {31'd0, u_if0.in_ready},  32'd1);
    send(1, 2); send(1, 2); send(1, 2);
    check_eq("mrst_pre_valid", {31'd0, u_if0.out_valid}, 32'd0);
    send(1, 2);
    drive(1'b0, 0, 0);
    check_eq("mrst_valid_end", {31'd0, u_if0.out_valid}, 32'd1);
    check_eq("mrst_data",      {24'd0, u_if0.out_data},  32'd8);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
